// File: rtl/dvi_in_pkg.sv
// Shared types and default sizes for the DVI input timing pipe.
package dvi_in_pkg;

    localparam int unsigned DEF_CW    = 8;
    localparam int unsigned DEF_NCH   = 3;
    localparam int unsigned DEF_CNT_W = 12;

    typedef enum logic [1:0] {
        LK_UNLOCKED = 2'd0,
        LK_CHECK    = 2'd1,
        LK_LOCKED   = 2'd2
    } lock_state_t;

endpackage

// File: rtl/dvi_in_delay.sv
// Clock-enable gated shift register; every stage holds while ce is low.
module dvi_in_delay #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr [DEPTH];

    // Shift one stage per enabled cycle; stage 0 takes the input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else if (ce) begin
            sr[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/dvi_in_timing_pipe.sv
// DVI receiver timing pipe: delays video, detects sync polarity, measures
// active width/height and tracks whether the timing is stable frame to frame.
module dvi_in_timing_pipe
    import dvi_in_pkg::*;
#(
    parameter int unsigned CW       = DEF_CW,
    parameter int unsigned NCH      = DEF_NCH,
    parameter int unsigned STAGES   = 2,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned NORM_POL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              de,
    input  logic              vsync,
    input  logic              hsync,
    input  logic [NCH*CW-1:0] pix_i,
    output logic              de_o,
    output logic              vsync_o,
    output logic              hsync_o,
    output logic [NCH*CW-1:0] pix_o,
    output logic [CNT_W-1:0]  hact_o,
    output logic [CNT_W-1:0]  vact_o,
    output logic              hs_pol_o,
    output logic              vs_pol_o,
    output logic              locked_o,
    output logic              timing_chg_o
);

    localparam int unsigned PW = NCH * CW;
    localparam int unsigned DW = PW + 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic de_q, vs_q;
    logic de_rise, de_fall, frame_edge;
    logic hs_n, vs_n;
    logic [DW-1:0] vid_d, vid_q;

    logic [CNT_W-1:0] line_cnt, hact_ref, line_idx;
    logic frame_bad, cnt_sat, armed;
    logic frame_valid, frame_match;

    lock_state_t state, state_nx;
    logic store, chg;

    assign de_rise    = ce & de & ~de_q;
    assign de_fall    = ce & ~de & de_q;
    // Raw-level history keeps a polarity update from faking a vsync edge.
    assign frame_edge = ce & (vs_pol_o ? (vsync & ~vs_q) : (~vsync & vs_q));

    // Sync normalisation uses the polarity registers as they stand this cycle.
    always_comb begin
        hs_n = hsync;
        vs_n = vsync;
        if (NORM_POL != 0) begin
            hs_n = hsync ^ ~hs_pol_o;
            vs_n = vsync ^ ~vs_pol_o;
        end
    end

    assign vid_d = {de, vs_n, hs_n, pix_i};

    dvi_in_delay #(
        .W     (DW),
        .DEPTH (STAGES)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .d   (vid_d),
        .q   (vid_q)
    );

    assign {de_o, vsync_o, hsync_o, pix_o} = vid_q;

    // Edge history and sync polarity sampled at the start of active video.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_q     <= 1'b0;
            vs_q     <= 1'b0;
            hs_pol_o <= 1'b1;
            vs_pol_o <= 1'b1;
        end else if (ce) begin
            de_q <= de;
            vs_q <= vsync;
            if (de & ~de_q) begin
                hs_pol_o <= ~hsync;
                vs_pol_o <= ~vsync;
            end
        end
    end

    // Per-line and per-frame measurement; a frame edge wins over a line edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_cnt  <= '0;
            hact_ref  <= '0;
            line_idx  <= '0;
            frame_bad <= 1'b0;
            cnt_sat   <= 1'b0;
            armed     <= 1'b0;
        end else if (ce) begin
            if (frame_edge) begin
                armed     <= 1'b1;
                frame_bad <= 1'b0;
                cnt_sat   <= 1'b0;
                line_idx  <= de_rise ? CNT_W'(1) : '0;
            end else begin
                if (de_rise) begin
                    if (line_idx == CNT_MAX) cnt_sat <= 1'b1;
                    else                     line_idx <= line_idx + CNT_W'(1);
                end
                if (de_fall) begin
                    if (line_cnt == CNT_MAX) cnt_sat <= 1'b1;
                    if (line_idx == CNT_W'(1)) begin
                        hact_ref <= line_cnt;
                    end else if (line_idx != '0 && line_cnt != hact_ref) begin
                        frame_bad <= 1'b1;
                    end
                end
            end
            if (de_rise) begin
                line_cnt <= CNT_W'(1);
            end else if (de && line_cnt != CNT_MAX) begin
                line_cnt <= line_cnt + CNT_W'(1);
            end
        end
    end

    assign frame_valid = armed & (line_idx != '0) & ~frame_bad & ~cnt_sat;
    assign frame_match = (hact_ref == hact_o) && (line_idx == vact_o);

    // Lock state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LK_UNLOCKED;
        else     state <= state_nx;
    end

    // Lock transitions, evaluated only at frame boundaries.
    always_comb begin
        state_nx = state;
        store    = 1'b0;
        chg      = 1'b0;
        if (frame_edge) begin
            unique case (state)
                LK_UNLOCKED: begin
                    if (frame_valid) begin
                        store    = 1'b1;
                        state_nx = LK_CHECK;
                    end
                end
                LK_CHECK: begin
                    if (!frame_valid) begin
                        state_nx = LK_UNLOCKED;
                    end else if (frame_match) begin
                        state_nx = LK_LOCKED;
                    end else begin
                        store = 1'b1;
                    end
                end
                LK_LOCKED: begin
                    if (!(frame_valid && frame_match)) begin
                        state_nx = LK_UNLOCKED;
                        chg      = 1'b1;
                    end
                end
                default: state_nx = LK_UNLOCKED;
            endcase
        end
    end

    // Registered status outputs and stored resolution.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_o     <= 1'b0;
            timing_chg_o <= 1'b0;
            hact_o       <= '0;
            vact_o       <= '0;
        end else begin
            locked_o     <= (state_nx == LK_LOCKED);
            timing_chg_o <= chg;
            if (store) begin
                hact_o <= hact_ref;
                vact_o <= line_idx;
            end
        end
    end

endmodule
